// File: rtl/timer_report_pkg.sv
// timer_report_pkg: shared FSM encoding, ASCII constants and sizing for the timer report path
package timer_report_pkg;
   localparam int DIGITS_DEF = 10;
   localparam int BIN_W      = 30;
   typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_CONVERT, ST_SEND} state_e;
   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_EQ = 8'h3D;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_u  = 8'h75;
   localparam logic [7:0] CH_m  = 8'h6D;
   localparam logic [7:0] CH_s  = 8'h73;
   localparam logic [7:0] CH_O  = 8'h4F;
   localparam logic [7:0] CH_V  = 8'h56;
   localparam logic [7:0] CH_F  = 8'h46;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   function automatic logic [7:0] digit_char(input logic [3:0] nib);
      return CH_0 | {4'b0000, nib};
   endfunction
endpackage

// File: rtl/timer_report_bin2bcd_seq.sv
// timer_report_bin2bcd_seq: iterative shift-add-3 binary to BCD, one input bit per cycle
module timer_report_bin2bcd_seq import timer_report_pkg::*; #(
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [BIN_W-1:0]    bin_i,
   output logic [4*DIGITS-1:0] bcd_o,
   output logic                done_o
);
   logic [BIN_W-1:0]    sh_q;
   logic [4*DIGITS-1:0] bcd_q, adj_d;
   logic [4:0]          cnt_q;
   logic                run_q, done_q;
   // add 3 to every digit that would overflow past 9 after the next shift
   always_comb begin
      adj_d = bcd_q;
      for (int k = 0; k < DIGITS; k++)
         adj_d[4*k +: 4] = bcd_q[4*k +: 4] > 4'd4 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
   end
   // load on start, then shift one binary bit into the BCD register per cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else if (start_i) begin
         sh_q   <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b1;
         done_q <= 1'b0;
      end else if (run_q) begin
         bcd_q <= {adj_d[4*DIGITS-2:0], sh_q[BIN_W-1]};
         sh_q  <= sh_q << 1;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'(BIN_W - 1)) begin
            run_q  <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end
   assign bcd_o  = bcd_q;
   assign done_o = done_q;
endmodule

// File: rtl/timer_report.sv
// timer_report: formats each timer measurement as an ASCII line and streams it to the UART
module timer_report import timer_report_pkg::*; #(
   parameter bit TIME_UNIT = 1'b1,
   parameter int DIGITS    = DIGITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stop_flag_i,
   input  logic [BIN_W-1:0] time_cost_i,
   input  logic             overflow_i,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   output logic             busy_o,
   output logic [7:0]       dropped_cnt_o
);
   state_e              state_q;
   logic                ovf_q, tx_valid_q, busy_q, done, last;
   logic [7:0]          tx_data_q, drop_q, byte_d;
   logic [5:0]          pos_q, pos_d, msd, di;
   logic [3:0]          nib;
   logic [4*DIGITS-1:0] bcd;
   timer_report_bin2bcd_seq #(.DIGITS(DIGITS)) u_bcd (
      .clk     (clk),
      .rst     (rst),
      .start_i (state_q == ST_CAPTURE),
      .bin_i   (time_cost_i),
      .bcd_o   (bcd),
      .done_o  (done)
   );
   // locate the most significant nonzero digit so leading zeros are skipped
   always_comb begin
      msd = '0;
      for (int k = 0; k < DIGITS; k++) msd = bcd[4*k +: 4] != 4'd0 ? 6'(k) : msd;
   end
   // byte following the current one; line is T = digits[msd..0] unit s CR LF
   always_comb begin
      pos_d = pos_q + 6'd1;
      di    = msd + 6'd2 - pos_d;
      nib   = '0;
      for (int k = 0; k < DIGITS; k++) nib = di == 6'(k) ? bcd[4*k +: 4] : nib;
      byte_d = pos_d == 6'd1 ? CH_EQ :
               ovf_q ? (pos_d == 6'd2 ? CH_O : pos_d == 6'd3 ? CH_V : pos_d == 6'd4 ? CH_F :
                        pos_d == 6'd5 ? CR : LF) :
               pos_d <= msd + 6'd2 ? digit_char(nib) :
               pos_d == msd + 6'd3 ? (TIME_UNIT ? CH_u : CH_m) :
               pos_d == msd + 6'd4 ? CH_s :
               pos_d == msd + 6'd5 ? CR : LF;
      last = ovf_q ? pos_q == 6'd6 : pos_q == msd + 6'd6;
   end
   // report sequencer: capture, wait for conversion, then hand bytes out one per acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ovf_q      <= 1'b0;
         pos_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_q <= stop_flag_i ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: begin
               ovf_q   <= overflow_i;
               busy_q  <= 1'b1;
               state_q <= ST_CONVERT;
            end
            ST_CONVERT: if (done) begin
               state_q    <= ST_SEND;
               pos_q      <= '0;
               tx_data_q  <= CH_T;
               tx_valid_q <= 1'b1;
            end
            ST_SEND: if (tx_ready_i) begin
               pos_q      <= pos_d;
               tx_data_q  <= last ? 8'h00 : byte_d;
               tx_valid_q <= !last;
               busy_q     <= !last;
               state_q    <= last ? ST_IDLE : ST_SEND;
            end
         endcase
      end
   end
   // count triggers that arrive while a report is already in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_q <= '0;
      else if (state_q != ST_IDLE && stop_flag_i && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
   end
   assign tx_data_o     = tx_data_q;
   assign tx_valid_o    = tx_valid_q;
   assign busy_o        = busy_q;
   assign dropped_cnt_o = drop_q;
endmodule

// File: tb/tb_timer_report.sv
// tb_timer_report: directed scoreboard bench for timer_report, us and ms instances in lockstep
module tb_timer_report;
   logic        clk = 1'b0, rst = 1'b1, stop_flag = 1'b0, overflow = 1'b0, tx_ready = 1'b0;
   logic [29:0] time_cost = '0;
   logic [7:0]  data_us, data_ms, drop_us, drop_ms;
   logic        valid_us, valid_ms, busy_us, busy_ms;
   int          tests = 0, fails = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_drop = 8'd0;
   always #5 clk = ~clk;
   timer_report #(.TIME_UNIT(1'b1), .DIGITS(10)) dut_us (
      .clk(clk), .rst(rst), .stop_flag_i(stop_flag), .time_cost_i(time_cost), .overflow_i(overflow),
      .tx_data_o(data_us), .tx_valid_o(valid_us), .tx_ready_i(tx_ready), .busy_o(busy_us),
      .dropped_cnt_o(drop_us));
   timer_report #(.TIME_UNIT(1'b0), .DIGITS(10)) dut_ms (
      .clk(clk), .rst(rst), .stop_flag_i(stop_flag), .time_cost_i(time_cost), .overflow_i(overflow),
      .tx_data_o(data_ms), .tx_valid_o(valid_ms), .tx_ready_i(tx_ready), .busy_o(busy_ms),
      .dropped_cnt_o(drop_ms));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic bump_drop();
      exp_drop = exp_drop == 8'hFF ? exp_drop : exp_drop + 8'd1;
   endtask
   task automatic push_line(input logic [29:0] tc, input logic ovf);
      string s;
      s = $sformatf("%0d", tc);
      exp_q.push_back(8'h54);
      exp_q.push_back(8'h3D);
      if (ovf) begin
         exp_q.push_back(8'h4F);
         exp_q.push_back(8'h56);
         exp_q.push_back(8'h46);
      end else begin
         for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
         exp_q.push_back(8'h75);
         exp_q.push_back(8'h73);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask
   task automatic run_msg(input string tag, input logic [29:0] tc, input logic ovf, input int pct,
                          input int n_stops, input bit lf_stop, input bit sat);
      int cyc, n, stops_left;
      bit prev_hold;
      logic [7:0] e, prev_data;
      stops_left = n_stops;
      push_line(tc, ovf);
      @(negedge clk);
      time_cost = tc;
      overflow  = ovf;
      stop_flag = 1'b1;
      @(negedge clk);
      if (!sat) stop_flag = 1'b0;
      cyc = 0;
      while (!valid_us && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check($sformatf("%s latency", tag), cyc, 32);
      check($sformatf("%s busy", tag), busy_us, 1'b1);
      prev_hold = 1'b0;
      prev_data = '0;
      n = 0;
      while (exp_q.size() > 0 && n < 2000) begin
         if (prev_hold) begin
            check($sformatf("%s hold data", tag), data_us, prev_data);
            check($sformatf("%s hold valid", tag), valid_us, 1'b1);
         end
         if (pct == 100) check($sformatf("%s no gap", tag), valid_us, 1'b1);
         if (sat && n == 300) begin
            stop_flag = 1'b0;
            exp_drop  = 8'hFF;
            check($sformatf("%s saturate", tag), drop_us, 8'hFF);
         end
         tx_ready = (sat && n < 300) ? 1'b0 : ($urandom_range(99) < pct);
         if (!sat) begin
            stop_flag = stops_left > 0 && n % 4 == 1 && exp_q.size() > 4;
            if (stop_flag) begin
               stops_left--;
               bump_drop();
            end
            if (lf_stop && exp_q.size() == 1 && valid_us && tx_ready) begin
               stop_flag = 1'b1;
               bump_drop();
            end
         end
         if (valid_us && tx_ready) begin
            e = exp_q.pop_front();
            check($sformatf("%s byte us", tag), data_us, e);
            check($sformatf("%s byte ms", tag), data_ms, e == 8'h75 ? 8'h6D : e);
            check($sformatf("%s valid ms", tag), valid_ms, 1'b1);
         end
         prev_hold = valid_us && !tx_ready;
         prev_data = data_us;
         @(negedge clk);
         n++;
      end
      stop_flag = 1'b0;
      tx_ready  = 1'b0;
      check($sformatf("%s all bytes", tag), exp_q.size(), 0);
      check($sformatf("%s end valid", tag), valid_us, 1'b0);
      check($sformatf("%s end busy", tag), busy_us, 1'b0);
      check($sformatf("%s end busy ms", tag), busy_ms, 1'b0);
      check($sformatf("%s dropped", tag), drop_us, exp_drop);
      check($sformatf("%s dropped ms", tag), drop_ms, exp_drop);
      exp_q.delete();
      if (lf_stop) begin
         repeat (40) @(negedge clk);
         check($sformatf("%s ignored valid", tag), valid_us, 1'b0);
         check($sformatf("%s ignored busy", tag), busy_us, 1'b0);
      end
   endtask
   initial begin
      int cyc;
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset data", data_us, 8'h00);
      check("reset valid", valid_us, 1'b0);
      check("reset busy", busy_us, 1'b0);
      check("reset dropped", drop_us, 8'h00);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_msg("zero", 30'd0, 1'b0, 100, 0, 1'b0, 1'b0);
      run_msg("mid", 30'd1234567, 1'b0, 100, 0, 1'b0, 1'b0);
      run_msg("max", 30'h3FFFFFFF, 1'b0, 100, 0, 1'b0, 1'b0);
      run_msg("ovf", 30'd999, 1'b1, 100, 0, 1'b0, 1'b0);
      run_msg("rnd mid", 30'd1234567, 1'b0, 30, 0, 1'b0, 1'b0);
      run_msg("rnd max", 30'h3FFFFFFF, 1'b0, 30, 0, 1'b0, 1'b0);
      run_msg("rnd ovf", 30'd12, 1'b1, 30, 0, 1'b0, 1'b0);
      run_msg("drops", 30'd987654321, 1'b0, 100, 3, 1'b0, 1'b0);
      run_msg("lf stop", 30'd42, 1'b0, 100, 0, 1'b1, 1'b0);
      run_msg("sat", 30'd5, 1'b0, 50, 0, 1'b0, 1'b1);
      stop_flag = 1'b1;
      @(negedge clk);
      stop_flag = 1'b0;
      cyc = 0;
      while (!valid_us && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("async rst valid", valid_us, 1'b0);
      check("async rst busy", busy_us, 1'b0);
      check("async rst dropped", drop_us, 8'h00);
      check("async rst valid ms", valid_ms, 1'b0);
      exp_drop = 8'd0;
      tx_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      run_msg("fresh", 30'd7, 1'b0, 100, 0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
